// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: LSB-first, one bit per clock through a shared carry/borrow flop.
// Latency: start accepted at edge k -> done high after edge k+WIDTH; start ignored while busy.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;

  logic ai, bi, sum_bit, cy_next;

  // One-bit full adder / full subtractor on the current LSBs.
  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0];
    sum_bit = ai ^ bi ^ cy_q;
    if (mode_q) begin
      cy_next = (~ai & bi) | (~(ai ^ bi) & cy_q);
    end else begin
      cy_next = (ai & bi) | ((ai ^ bi) & cy_q);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          cnt_d   = '0;
          cy_d    = 1'b0;
        end
      end
      RUN: begin
        // Result enters at the MSB so bit 0 lands in position 0 after WIDTH shifts.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        cy_d  = cy_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
    end
  end

  // The carry/borrow flop holds the final carry after the last bit, so it doubles as cout.
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cy_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed, random (WIDTH=8) and exhaustive (WIDTH=4) checks.
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       start8, mode8, busy8, done8, cout8;
  logic [7:0] a8, b8, res8;
  logic       start4, mode4, busy4, done4, cout4;
  logic [3:0] a4, b4, res4;

  int check_cnt = 0;
  int pass_cnt  = 0;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, check_cnt);
    $fatal(1);
  end

  // Reference: plain integer arithmetic, carry/borrow = result outside 0..2^w-1.
  function automatic logic [8:0] ref_op(input int w, input bit m, input int x, input int y);
    int s;
    int lim;
    logic [8:0] r;
    lim = 1 << w;
    s = m ? (x - y) : (x + y);
    r = '0;
    r[7:0] = 8'(s & (lim - 1));
    r[8] = (s < 0) || (s >= lim);
    return r;
  endfunction

  // Called just after a clock edge with the DUT in IDLE; returns with the DUT back in IDLE.
  task automatic do_op(input bit w4, input bit m, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [7:0] r, output logic c);
    lat = -1;
    r = 8'hxx;
    c = 1'bx;
    if (w4) begin
      start4 = 1'b1; mode4 = m; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      start8 = 1'b1; mode8 = m; a8 = av; b8 = bv;
    end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (w4 ? done4 : done8) begin
        lat = i;
        r = w4 ? {4'b0, res4} : res8;
        c = w4 ? cout4 : cout8;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy8); else pass_cnt++;
    check_cnt++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b want 0", done8); else pass_cnt++;
    check_cnt++; if (res8 !== 8'h00) $display("FAIL reset_result: got %h want 00", res8); else pass_cnt++;
    check_cnt++; if (cout8 !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout8); else pass_cnt++;
    // First edge with rst low and start high must accept.
    rst = 1'b0; start8 = 1'b1; mode8 = 1'b0; a8 = 8'h21; b8 = 8'h13;
    @(posedge clk); #1;
    start8 = 1'b0;
    check_cnt++; if (busy8 !== 1'b1) $display("FAIL first_start_accept: busy got %b want 1", busy8); else pass_cnt++;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done8) lat = i;
    end
    check_cnt++; if (lat !== 8 || res8 !== 8'h34) $display("FAIL first_start_result: lat %0d res %h want 8 34", lat, res8); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] av[5] = '{8'h0F, 8'h05, 8'h07, 8'hFF, 8'h00};
    logic [7:0] bv[5] = '{8'h01, 8'h07, 8'h05, 8'h01, 8'h00};
    bit         mv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] rv[5] = '{8'h10, 8'hFE, 8'h02, 8'h00, 8'h00};
    bit         cv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    logic [7:0] r;
    logic c;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, mv[i], av[i], bv[i], lat, r, c);
      check_cnt++; if (lat !== 8) $display("FAIL dir%0d_latency: got %0d want 8", i, lat); else pass_cnt++;
      check_cnt++; if (r !== rv[i]) $display("FAIL dir%0d_result: got %h want %h", i, r, rv[i]); else pass_cnt++;
      check_cnt++; if (c !== cv[i]) $display("FAIL dir%0d_cout: got %b want %b", i, c, cv[i]); else pass_cnt++;
    end
    // Outputs hold in IDLE after the last operation.
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (res8 !== 8'h00 || cout8 !== 1'b0 || busy8 !== 1'b0) $display("FAIL idle_hold: res %h cout %b busy %b want 00 0 0", res8, cout8, busy8); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] r, x, y;
    logic c;
    logic [8:0] e;
    bit m;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); m = 1'($urandom_range(0, 1));
      e = ref_op(8, m, int'(x), int'(y));
      do_op(1'b0, m, x, y, lat, r, c);
      check_cnt++; if (lat !== 8 || r !== e[7:0] || c !== e[8]) $display("FAIL rand%0d m=%b a=%h b=%h: lat %0d res %h cout %b want 8 %h %b", i, m, x, y, lat, r, c, e[7:0], e[8]); else pass_cnt++;
    end
  endtask

  task automatic test_busy_protection();
    int pulses;
    int lat;
    logic [7:0] r;
    logic c;
    logic busy_gap;
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'h10; b8 = 8'h03;
    @(posedge clk); #1;
    mode8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;  // start stays high
    pulses = 0; lat = -1; r = 8'hxx; c = 1'bx; busy_gap = 1'bx;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++; lat = i; r = res8; c = cout8;
      end
      if (i == 9) busy_gap = busy8;
    end
    check_cnt++; if (pulses !== 1) $display("FAIL busy_pulses: got %0d want 1", pulses); else pass_cnt++;
    check_cnt++; if (lat !== 8) $display("FAIL busy_latency: got %0d want 8", lat); else pass_cnt++;
    check_cnt++; if (r !== 8'h0D || c !== 1'b0) $display("FAIL busy_result: got %h %b want 0d 0", r, c); else pass_cnt++;
    check_cnt++; if (busy_gap !== 1'b0) $display("FAIL busy_idle_gap: got %b want 0", busy_gap); else pass_cnt++;
    @(posedge clk); #1;
    start8 = 1'b0;
    check_cnt++; if (busy8 !== 1'b1) $display("FAIL busy_reaccept: got %b want 1", busy8); else pass_cnt++;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; r = res8; c = cout8; end
    end
    check_cnt++; if (lat !== 8 || r !== 8'hFF || c !== 1'b0) $display("FAIL busy_second_op: lat %0d res %h cout %b want 8 ff 0", lat, r, c); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    logic [7:0] r;
    logic c;
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h7F; b8 = 8'h91;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cnt++; if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL midrst_flags: busy %b done %b want 0 0", busy8, done8); else pass_cnt++;
    check_cnt++; if (res8 !== 8'h00 || cout8 !== 1'b0) $display("FAIL midrst_outputs: res %h cout %b want 00 0", res8, cout8); else pass_cnt++;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) pulses++;
    end
    check_cnt++; if (pulses !== 0) $display("FAIL midrst_no_done: got %0d active cycles want 0", pulses); else pass_cnt++;
    do_op(1'b0, 1'b1, 8'h3C, 8'h5A, lat, r, c);
    check_cnt++; if (lat !== 8 || r !== 8'hE2 || c !== 1'b1) $display("FAIL midrst_recover: lat %0d res %h cout %b want 8 e2 1", lat, r, c); else pass_cnt++;
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [7:0] r;
    logic c;
    logic [8:0] e;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          e = ref_op(4, 1'(m), x, y);
          do_op(1'b1, 1'(m), 8'(x), 8'(y), lat, r, c);
          check_cnt++; if (lat !== 4 || r !== e[7:0] || c !== e[8]) $display("FAIL exh4 m=%0d a=%0d b=%0d: lat %0d res %h cout %b want 4 %h %b", m, x, y, lat, r, c, e[7:0], e[8]); else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_protection();
    test_reset_mid();
    test_exhaustive4();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
